// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// State encodings are visible on the LEDs, so their values are fixed.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StLap   = 2'd3
    } state_e;

    // One second of continuous press at 100 MHz.
    localparam int unsigned HoldCyclesDefault = 100_000_000;

    function automatic logic counting(state_e s);
        return (s == StRun) || (s == StLap);
    endfunction

    function automatic logic holding(state_e s);
        return s == StLap;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and counter/display commands between the stopwatch controller
// (master) and the datapath side that consumes its commands (slave).
interface stopwatch_if;

    logic       start_btn;
    logic       lap_btn;
    logic       count_en;
    logic       count_clr;
    logic       lap_capture;
    logic       display_hold;
    logic [1:0] state_o;

    modport master (
        input  start_btn,
        input  lap_btn,
        output count_en,
        output count_clr,
        output lap_capture,
        output display_hold,
        output state_o
    );

    modport slave (
        output start_btn,
        output lap_btn,
        input  count_en,
        input  count_clr,
        input  lap_capture,
        input  display_hold,
        input  state_o
    );

endinterface

// File: rtl/button_event.sv
// Rising-edge press detector with an optional saturating hold counter that
// flags a long press once per continuous hold.
module button_event #(
    parameter bit          HoldEn     = 1'b0,
    parameter int unsigned HoldCycles = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o,
    output logic long_press_o
);

    localparam int unsigned CntW = $clog2(HoldCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] CntSat  = CntW'(HoldCycles);

    logic            prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Previous level resets high so a button held through reset is not a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign press_o = btn_i & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!HoldEn || !btn_i) begin
            cnt_d = '0;
        end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the edge that records the HoldCycles-th consecutive high sample;
    // saturation keeps it from firing again until release.
    assign long_press_o = HoldEn && btn_i && (cnt_q == CntLast);

endmodule

// File: rtl/stopwatch_controller.sv
// Turns debounced start/lap button levels into run, pause, lap and clear
// commands for the time counter and display-hold logic. Moore, registered outputs.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HoldCyclesDefault
) (
    input logic         clk,
    input logic         rst,
    stopwatch_if.master bus
);

    logic start_press, start_long;
    logic lap_press, lap_long;

    button_event #(
        .HoldEn     (1'b1),
        .HoldCycles (HOLD_CYCLES)
    ) u_start_event (
        .clk          (clk),
        .rst          (rst),
        .btn_i        (bus.start_btn),
        .press_o      (start_press),
        .long_press_o (start_long)
    );

    button_event #(
        .HoldEn     (1'b0),
        .HoldCycles (HOLD_CYCLES)
    ) u_lap_event (
        .clk          (clk),
        .rst          (rst),
        .btn_i        (bus.lap_btn),
        .press_o      (lap_press),
        .long_press_o (lap_long)
    );

    state_e state_q, state_d;
    logic   clr_d, cap_d;
    logic   count_en_q, count_clr_q, lap_capture_q, display_hold_q;

    // Priority: long press, then start press, then lap press.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        cap_d   = 1'b0;
        if (start_long || lap_long) begin
            state_d = StIdle;
            clr_d   = 1'b1;
        end else if (start_press) begin
            case (state_q)
                StRun, StLap: state_d = StPause;
                default:      state_d = StRun;
            endcase
        end else if (lap_press) begin
            case (state_q)
                StRun: begin
                    state_d = StLap;
                    cap_d   = 1'b1;
                end
                StLap: state_d = StRun;
                StPause: begin
                    state_d = StIdle;
                    clr_d   = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            count_en_q     <= 1'b0;
            count_clr_q    <= 1'b0;
            lap_capture_q  <= 1'b0;
            display_hold_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_en_q     <= counting(state_d);
            count_clr_q    <= clr_d;
            lap_capture_q  <= cap_d;
            display_hold_q <= holding(state_d);
        end
    end

    assign bus.state_o      = state_q;
    assign bus.count_en     = count_en_q;
    assign bus.count_clr    = count_clr_q;
    assign bus.lap_capture  = lap_capture_q;
    assign bus.display_hold = display_hold_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller: directed scenarios plus random
// button traffic compared against a behavioural model of the press rules.
module tb_stopwatch_controller;

    localparam int unsigned HOLD = 8;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stopwatch_if bus ();

    stopwatch_controller #(
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    // Behavioural model: state as an integer, run length of the start button.
    int m_state;
    bit m_ps, m_pl, m_clr, m_cap;
    int m_run;

    task automatic model_reset();
        m_state = IDLE;
        m_ps    = 1'b1;
        m_pl    = 1'b1;
        m_clr   = 1'b0;
        m_cap   = 1'b0;
        m_run   = 0;
    endtask

    task automatic model_step(input bit s, input bit l);
        bit sp, lp;
        sp    = s && !m_ps;
        lp    = l && !m_pl;
        m_clr = 1'b0;
        m_cap = 1'b0;
        m_run = s ? m_run + 1 : 0;
        if (m_run == HOLD) begin
            m_state = IDLE;
            m_clr   = 1'b1;
        end else if (sp) begin
            m_state = (m_state == RUN || m_state == LAP) ? PAUSE : RUN;
        end else if (lp) begin
            if (m_state == RUN) begin
                m_state = LAP;
                m_cap   = 1'b1;
            end else if (m_state == LAP) begin
                m_state = RUN;
            end else if (m_state == PAUSE) begin
                m_state = IDLE;
                m_clr   = 1'b1;
            end
        end
        m_ps = s;
        m_pl = l;
    endtask

    // {state[1:0], count_en, count_clr, lap_capture, display_hold}
    function automatic logic [5:0] m_vec();
        logic [1:0] st;
        st = m_state[1:0];
        return {st, (m_state == RUN || m_state == LAP), m_clr, m_cap, (m_state == LAP)};
    endfunction

    function automatic logic [5:0] got_vec();
        return {bus.state_o, bus.count_en, bus.count_clr, bus.lap_capture, bus.display_hold};
    endfunction

    task automatic drive(input bit s, input bit l);
        @(negedge clk);
        bus.start_btn = s;
        bus.lap_btn   = l;
        @(posedge clk);
        #1;
        model_step(s, l);
    endtask

    task automatic assert_rst();
        rst = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_step(bus.start_btn, bus.lap_btn);
    endtask

    task automatic test_reset();
        bus.start_btn = 1'b0;
        bus.lap_btn   = 1'b0;
        assert_rst();
        checks++;
        if (got_vec() !== 6'd0) $display("FAIL reset_low got=%b exp=%b", got_vec(), 6'd0);
        else passed++;
        release_rst();
        drive(1'b0, 1'b0);
        checks++;
        if (got_vec() !== m_vec()) $display("FAIL reset_idle got=%b exp=%b", got_vec(), m_vec());
        else passed++;
        bus.start_btn = 1'b1;
        assert_rst();
        release_rst();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.state_o !== 2'd0 || got_vec() !== m_vec())
                $display("FAIL reset_held c=%0d got=%b exp=%b", c, got_vec(), m_vec());
            else passed++;
            drive(1'b1, 1'b0);
        end
        drive(1'b0, 1'b0);
        checks++;
        if (got_vec() !== 6'd0) $display("FAIL reset_held_release got=%b exp=%b", got_vec(), 6'd0);
        else passed++;
    endtask

    task automatic test_start();
        logic [1:0] exp_st [3] = '{2'd1, 2'd2, 2'd1};
        logic       exp_en [3] = '{1'b1, 1'b0, 1'b1};
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 5; c++) begin
                drive(c < 3, 1'b0);
                checks++;
                if (got_vec() !== m_vec())
                    $display("FAIL start_seq p=%0d c=%0d got=%b exp=%b", p, c, got_vec(), m_vec());
                else passed++;
                if (c == 0) begin
                    checks++;
                    if ({bus.state_o, bus.count_en} !== {exp_st[p], exp_en[p]})
                        $display("FAIL start_edge p=%0d got=%b exp=%b", p,
                                 {bus.state_o, bus.count_en}, {exp_st[p], exp_en[p]});
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_lap();
        // {state, count_en, lap_capture, display_hold}
        logic [4:0] exp_lap [2] = '{5'b11_1_1_1, 5'b01_1_0_0};
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 5; c++) begin
                drive(1'b0, c < 3);
                checks++;
                if (got_vec() !== m_vec())
                    $display("FAIL lap_seq p=%0d c=%0d got=%b exp=%b", p, c, got_vec(), m_vec());
                else passed++;
                if (c == 0) begin
                    checks++;
                    if ({bus.state_o, bus.count_en, bus.lap_capture, bus.display_hold} !== exp_lap[p])
                        $display("FAIL lap_edge p=%0d got=%b exp=%b", p,
                                 {bus.state_o, bus.count_en, bus.lap_capture, bus.display_hold},
                                 exp_lap[p]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_pause_clear();
        for (int c = 0; c < 4; c++) drive(c < 3, 1'b0);
        checks++;
        if (bus.state_o !== 2'd2) $display("FAIL pause_enter got=%0d exp=2", bus.state_o);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c < 2);
            checks++;
            if (got_vec() !== m_vec())
                $display("FAIL pause_clear c=%0d got=%b exp=%b", c, got_vec(), m_vec());
            else passed++;
            if (c < 2) begin
                checks++;
                if ({bus.state_o, bus.count_clr} !== {2'd0, (c == 0)})
                    $display("FAIL pause_clr_pulse c=%0d got=%b exp=%b", c,
                             {bus.state_o, bus.count_clr}, {2'd0, (c == 0)});
                else passed++;
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c < 2);
            checks++;
            if (got_vec() !== 6'd0) $display("FAIL idle_lap c=%0d got=%b exp=%b", c, got_vec(), 6'd0);
            else passed++;
        end
    endtask

    task automatic test_long_press();
        for (int c = 0; c < 5; c++) drive(c < 3, 1'b0);
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (got_vec() !== m_vec())
                $display("FAIL long_seq c=%0d got=%b exp=%b", c, got_vec(), m_vec());
            else passed++;
            if (c == 0 || c >= 7) begin
                checks++;
                if (c == 0 && bus.state_o !== 2'd2)
                    $display("FAIL long_first_edge got=%0d exp=2", bus.state_o);
                else if (c == 7 && {bus.state_o, bus.count_clr} !== 3'b00_1)
                    $display("FAIL long_fire got=%b exp=001", {bus.state_o, bus.count_clr});
                else if (c > 7 && bus.count_clr !== 1'b0)
                    $display("FAIL long_refire c=%0d got=%b exp=0", c, bus.count_clr);
                else passed++;
            end
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (got_vec() !== m_vec())
                $display("FAIL long_release c=%0d got=%b exp=%b", c, got_vec(), m_vec());
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < 5; c++) drive(c < 3, 1'b0);
        for (int c = 0; c < 4; c++) begin
            drive(c < 2, c < 2);
            checks++;
            if (got_vec() !== m_vec())
                $display("FAIL simul_seq c=%0d got=%b exp=%b", c, got_vec(), m_vec());
            else passed++;
            if (c == 0) begin
                checks++;
                if ({bus.state_o, bus.lap_capture} !== 3'b10_0)
                    $display("FAIL simul_edge got=%b exp=100", {bus.state_o, bus.lap_capture});
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) drive(c < 2, 1'b0);
        for (int c = 0; c < 4; c++) drive(1'b0, c < 2);
        checks++;
        if (got_vec() !== m_vec() || bus.state_o !== 2'd3)
            $display("FAIL mid_pre got=%b exp=%b", got_vec(), m_vec());
        else passed++;
        #2;
        assert_rst();
        checks++;
        if (got_vec() !== 6'd0) $display("FAIL mid_async got=%b exp=%b", got_vec(), 6'd0);
        else passed++;
        release_rst();
        drive(1'b0, 1'b0);
        checks++;
        if (got_vec() !== m_vec()) $display("FAIL mid_after got=%b exp=%b", got_vec(), m_vec());
        else passed++;
    endtask

    task automatic test_random();
        bit s, l;
        s = 1'b0;
        l = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                assert_rst();
                checks++;
                if (got_vec() !== 6'd0) $display("FAIL rand_rst i=%0d got=%b exp=%b", i, got_vec(), 6'd0);
                else passed++;
                release_rst();
            end
            s = s ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 25);
            l = l ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 15);
            drive(s, l);
            checks++;
            if (got_vec() !== m_vec())
                $display("FAIL rand i=%0d s=%b l=%b got=%b exp=%b", i, s, l, got_vec(), m_vec());
            else passed++;
        end
    endtask

    initial begin
        bus.start_btn = 1'b0;
        bus.lap_btn   = 1'b0;
        model_reset();
        test_reset();
        test_start();
        test_lap();
        test_pause_clear();
        test_long_press();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
